ps2_transmitter: RTL and testbench
==================================

Name: ps2_transmitter

Overview:
Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED LED set or 0xF4 enable) to a keyboard or mouse over the shared open-drain ps2c/ps2d lines. It pairs with the existing PS/2 receiver on the same pins. tx_idle gates the receiver's rx_en so the receiver never decodes our own frame.

Parameters:
RTS_CYCLES, 5000, clk cycles the host holds ps2c low before the start bit (100 us at 50 MHz).
TIMEOUT_CYCLES, 750000, max clk cycles between device falling edges before abort (15 ms at 50 MHz).
FILTER_LEN, 8, depth of the ps2c glitch filter shift register.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
wr_ps2  in  1  one-cycle request to send din; honoured only when tx_idle=1
din  in  8  command byte, latched on accepted wr_ps2
ps2c  inout  1  PS/2 clock, open-drain: drive 0 or Z, never drive 1
ps2d  inout  1  PS/2 data, open-drain: drive 0 or Z, never drive 1
tx_idle  out  1  1 when in idle state
tx_done_tick  out  1  one-cycle pulse when a frame ends (success or abort)
ack_err  out  1  status of last frame; 1 = no device ACK, or timeout; valid from tx_done_tick until next accept

Behaviour:
- Reset (async): state=idle, both lines released (Z), tx_idle=1, tx_done_tick=0, ack_err=0, counters=0, filter=all 1s, filtered clock=1.
- Clock filter:
  - FILTER_LEN-bit shift register samples ps2c each clk.
  - Filtered clock goes to 1 when the register is all 1s, goes to 0 when it is all 0s, and holds otherwise.
  - fall_edge = filtered_reg & ~filtered_next.
- Frame register b (9 bits) = {parity, din}, with parity = ~^din (odd parity). Loaded on accept.
- Bit counter n (4 bits). Timer t (20 bits), cleared on entry to each state and on every fall_edge.
- States and transitions:
  - idle: lines Z. If wr_ps2=1: load b, t=0, go to rts. If wr_ps2=0: stay.
  - rts: drive ps2c=0, ps2d=Z. When t==RTS_CYCLES-1: go to start.
  - start: drive ps2d=0 (start bit), release ps2c. On fall_edge (device clock #1): n=8, go to data.
  - data: drive ps2d=0 when b[0]=0, else Z. On each fall_edge: b shifts right. If n==0, go to stop; otherwise n=n-1. Fall edges #2..#10 present d0..d7 then parity.
  - stop: ps2d=Z (stop bit = 1). On fall_edge #11: sample ps2d, set ack_err = ps2d (device must pull low), pulse tx_done_tick, go to idle.
- Timeout: in start, data or stop, if t reaches TIMEOUT_CYCLES-1 with no fall_edge: release lines, ack_err=1, pulse tx_done_tick, go to idle.
- Total latency from accept to tx_done_tick = RTS_CYCLES + 11 device clock periods + filter delay.
- wr_ps2 while tx_idle=0: ignored, no queueing, din not latched.
- wr_ps2 in the same cycle as tx_done_tick: ignored; idle accepts from the next cycle.
- Reset mid-frame: lines released immediately, no done tick.
- Line driving: the output enable is asserted only when driving 0. Both lines are never driven simultaneously with a value of 1.

Decomposition:
- Package ps2_pkg:
  - state encoding (idle, rts, start, data, stop; 3 bits)
  - default RTS and timeout cycle constants
  - parity helper function
- Sub-module ps2_clk_filter: ps2c glitch filter and falling-edge detector, reused by the receiver.

Test Plan:
1. Send 0xED; device model clocks at 12.5 kHz and ACKs. Required: ps2c low for exactly 5000 cycles; bits observed at device rising edges = 0, 1,0,1,1,0,1,1,1, parity 1, stop 1; ack_err=0; one tx_done_tick; tx_idle returns to 1.
2. Send 0x00. Required: parity bit = 1; ps2d never driven high (check for X/contention on the bus model); ack_err=0.
3. Device model withholds ACK (ps2d stays Z at clock #11). Required: ack_err=1, tx_done_tick pulses once.
4. Device stops clocking after bit 4. Required: abort after 750000 idle cycles; lines released; ack_err=1; tx_done_tick=1.
5. Pulse wr_ps2 with 0xF4 mid-frame of a 0xFF transfer. Required: the 0xFF frame completes unchanged; no second frame is sent.
6. Assert reset during the data state. Required: both lines go Z in the same cycle, tx_idle=1, no tx_done_tick; a subsequent 0xF4 send completes with ack_err=0.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types, defaults and helpers for the PS/2 host-side blocks
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RTS,
        START,
        DATA,
        STOP
    } state_t;

    localparam int RTS_CYCLES_DEF     = 5000;
    localparam int TIMEOUT_CYCLES_DEF = 750000;
    localparam int FILTER_LEN_DEF     = 8;
    localparam int TIMER_W            = 20;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// ps2_clk_filter: deglitches ps2c and flags each falling edge of the filtered clock
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    output logic fall_edge
);

    logic [FILTER_LEN-1:0] filter;
    logic                  clk_f;
    logic                  clk_f_next;

    // filtered clock only changes once the whole window agrees
    always_comb begin
        clk_f_next = (&filter) ? 1'b1 : (~|filter) ? 1'b0 : clk_f;
        fall_edge  = clk_f & ~clk_f_next;
    end

    // shift the raw line in at the top of the window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filter <= '1;
            clk_f  <= 1'b1;
        end else begin
            filter <= {ps2c, filter[FILTER_LEN-1:1]};
            clk_f  <= clk_f_next;
        end
    end

endmodule

// File: rtl/ps2_transmitter.sv
// ps2_transmitter: host-to-device PS/2 command sender over open-drain clock/data lines
module ps2_transmitter
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES     = RTS_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    state_t               state, state_next;
    logic [8:0]           b, b_next;
    logic [3:0]           n, n_next;
    logic [TIMER_W-1:0]   t, t_next;
    logic                 ack_next;
    logic                 done_next;
    logic                 c_oe, d_oe;
    logic                 fall_edge;
    logic                 timeout;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .clk      (clk),
        .reset    (reset),
        .ps2c     (ps2c),
        .fall_edge(fall_edge)
    );

    // lines are only ever pulled low; released lines float to the pull-up
    assign ps2c    = c_oe ? 1'b0 : 1'bz;
    assign ps2d    = d_oe ? 1'b0 : 1'bz;
    assign tx_idle = (state == IDLE);
    assign timeout = (t == TIMER_W'(TIMEOUT_CYCLES - 1));

    // next-state, frame shifting and line enables
    always_comb begin
        state_next = state;
        b_next     = b;
        n_next     = n;
        t_next     = t + TIMER_W'(1);
        ack_next   = ack_err;
        done_next  = 1'b0;
        c_oe       = 1'b0;
        d_oe       = 1'b0;
        case (state)
            IDLE: begin
                t_next = '0;
                if (wr_ps2 && !tx_done_tick) begin
                    b_next     = {odd_parity(din), din};
                    ack_next   = 1'b0;
                    state_next = RTS;
                end
            end
            RTS: begin
                c_oe = 1'b1;
                if (t == TIMER_W'(RTS_CYCLES - 1)) begin
                    t_next     = '0;
                    state_next = START;
                end
            end
            START: begin
                d_oe = 1'b1;
                if (fall_edge) begin
                    t_next     = '0;
                    n_next     = 4'd8;
                    state_next = DATA;
                end
            end
            DATA: begin
                d_oe = ~b[0];
                if (fall_edge) begin
                    t_next     = '0;
                    b_next     = {1'b0, b[8:1]};
                    n_next     = (n == 4'd0) ? n : n - 4'd1;
                    state_next = (n == 4'd0) ? STOP : DATA;
                end
            end
            STOP: begin
                if (fall_edge) begin
                    t_next     = '0;
                    ack_next   = ps2d;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if ((state == START || state == DATA || state == STOP) && !fall_edge && timeout) begin
            t_next     = '0;
            ack_next   = 1'b1;
            done_next  = 1'b1;
            state_next = IDLE;
        end
    end

    // state and datapath registers; done is registered so it lines up with ack_err
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            b            <= '0;
            n            <= '0;
            t            <= '0;
            ack_err      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            state        <= state_next;
            b            <= b_next;
            n            <= n_next;
            t            <= t_next;
            ack_err      <= ack_next;
            tx_done_tick <= done_next;
        end
    end

endmodule

// File: tb/tb_ps2_transmitter.sv
// tb_ps2_transmitter: directed frames against a simple PS/2 device model
module tb_ps2_transmitter;

    localparam int RTS  = 50;
    localparam int TMO  = 300;
    localparam int FLEN = 8;
    localparam int HALF = 25;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_ps2 = 1'b0;
    logic [7:0] din = 8'h00;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle;
    logic       tx_done_tick;
    logic       ack_err;
    logic       dev_c = 1'b0;
    logic       dev_d = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int rts_run = 0;
    int rts_len = 0;
    int rts_cnt = 0;
    int x_cnt = 0;

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c ? 1'b0 : 1'bz;
    assign ps2d = dev_d ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    ps2_transmitter #(.RTS_CYCLES(RTS), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_ps2      (wr_ps2),
        .din         (din),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .tx_idle     (tx_idle),
        .tx_done_tick(tx_done_tick),
        .ack_err     (ack_err)
    );

    // bus monitor: done pulses, undefined bus values, host request-to-send lengths
    always @(negedge clk) begin
        if (tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;
        if (ps2c === 1'bx || ps2d === 1'bx) x_cnt <= x_cnt + 1;
        if (!dev_c && ps2c === 1'b0) rts_run <= rts_run + 1;
        else if (rts_run > 0) begin
            rts_len <= rts_run;
            rts_cnt <= rts_cnt + 1;
            rts_run <= 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got running required finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        @(negedge clk);
        din    = d;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
    endtask

    task automatic device(input int nfall, input bit ack, output logic [10:0] bits);
        int w;
        bits = '0;
        w = 0;
        while (!(ps2c === 1'b1 && ps2d === 1'b0) && w < RTS + 100) begin
            @(negedge clk);
            w++;
        end
        check("dev_start", {30'b0, ps2c, ps2d}, 32'h2);
        if (ps2c === 1'b1 && ps2d === 1'b0) begin
            repeat (HALF) @(negedge clk);
            bits[0] = ps2d;
            for (int i = 1; i <= nfall; i++) begin
                dev_c = 1'b1;
                repeat (HALF) @(negedge clk);
                if (i <= 10) bits[i] = ps2d;
                dev_c = 1'b0;
                if (i == 10 && ack) dev_d = 1'b1;
                if (i == 11) dev_d = 1'b0;
                repeat (HALF) @(negedge clk);
            end
            dev_d = 1'b0;
        end
    endtask

    initial begin
        logic [10:0] bits;
        int d0, r0, cyc;

        repeat (3) @(negedge clk);
        check("rst_idle", tx_idle, 1);
        check("rst_done", tx_done_tick, 0);
        check("rst_ack", ack_err, 0);
        check("rst_c", ps2c, 1);
        check("rst_d", ps2d, 1);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // 0xED with ACK
        d0 = done_cnt;
        send(8'hED);
        device(11, 1, bits);
        repeat (3) @(negedge clk);
        check("ed_bits", bits, 11'b1_1_11101101_0);
        check("ed_rts_len", rts_len, RTS);
        check("ed_ack", ack_err, 0);
        check("ed_done", done_cnt - d0, 1);
        check("ed_idle", tx_idle, 1);

        // 0x00 with ACK: parity 1, no contention
        d0 = done_cnt;
        send(8'h00);
        device(11, 1, bits);
        repeat (3) @(negedge clk);
        check("z_bits", bits, 11'b1_1_00000000_0);
        check("z_xbus", x_cnt, 0);
        check("z_ack", ack_err, 0);
        check("z_done", done_cnt - d0, 1);

        // no ACK; a request landing on the done cycle is dropped
        d0 = done_cnt;
        r0 = rts_cnt;
        send(8'h5A);
        fork
            device(11, 0, bits);
            begin
                cyc = 0;
                while (tx_done_tick !== 1'b1 && cyc < 2000) begin
                    @(negedge clk);
                    cyc++;
                end
                din    = 8'hF4;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        join
        repeat (3 * RTS) @(negedge clk);
        check("na_bits", bits, 11'b1_1_01011010_0);
        check("na_ack", ack_err, 1);
        check("na_done", done_cnt - d0, 1);
        check("na_no_resend", rts_cnt - r0, 1);
        check("na_idle", tx_idle, 1);

        // device stops clocking: timeout abort
        d0 = done_cnt;
        send(8'h3C);
        device(5, 0, bits);
        cyc = 0;
        while (tx_done_tick !== 1'b1 && cyc < TMO + 200) begin
            @(negedge clk);
            cyc++;
        end
        check("to_done_seen", tx_done_tick, 1);
        check("to_ack", ack_err, 1);
        check("to_lo", (2 * HALF + cyc) >= TMO + FLEN, 1);
        check("to_hi", (2 * HALF + cyc) <= TMO + FLEN + 3, 1);
        @(negedge clk);
        check("to_c", ps2c, 1);
        check("to_d", ps2d, 1);
        check("to_idle", tx_idle, 1);
        check("to_done", done_cnt - d0, 1);

        // 0xFF with an ignored mid-frame 0xF4 request
        d0 = done_cnt;
        r0 = rts_cnt;
        send(8'hFF);
        fork
            device(11, 1, bits);
            begin
                repeat (RTS + 150) @(negedge clk);
                din    = 8'hF4;
                wr_ps2 = 1'b1;
                @(negedge clk);
                wr_ps2 = 1'b0;
            end
        join
        repeat (3 * RTS) @(negedge clk);
        check("ff_bits", bits, 11'b1_1_11111111_0);
        check("ff_ack", ack_err, 0);
        check("ff_done", done_cnt - d0, 1);
        check("ff_one_frame", rts_cnt - r0, 1);
        check("ff_idle", tx_idle, 1);

        // reset during data, then a clean 0xF4
        d0 = done_cnt;
        send(8'hF4);
        device(4, 0, bits);
        check("rs_pre_d", ps2d, 0);
        check("rs_pre_idle", tx_idle, 0);
        #2 reset = 1'b1;
        #1;
        check("rs_c", ps2c, 1);
        check("rs_d", ps2d, 1);
        check("rs_idle", tx_idle, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rs_no_done", done_cnt - d0, 0);
        d0 = done_cnt;
        send(8'hF4);
        device(11, 1, bits);
        repeat (3) @(negedge clk);
        check("f4_bits", bits, 11'b1_0_11110100_0);
        check("f4_ack", ack_err, 0);
        check("f4_done", done_cnt - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
